// File: rtl/cnn_vote_pkg.sv
// Shared widths, default class codes and FSM encoding for the CNN class vote tracker.
package cnn_vote_pkg;

  localparam int CLS_W             = 4;
  localparam int ADDR_W            = 19;
  localparam int HIST_W            = 16;
  localparam int ERR_W             = 4;
  localparam int CNN_NUM_CLASSES   = 10;
  localparam int CNN_HEALTHY_CLASS = 7;
  localparam int CNN_ADDR_LIMIT    = 512000;

  typedef logic [CLS_W-1:0] cls_t;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_TALLY  = 2'd1;
  localparam logic [1:0] ST_DECIDE = 2'd2;

  // Counter width that stays at least one bit for tiny ranges.
  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/vote_history.sv
// Shift register of the most recent accepted class codes (newest at entry 0) plus fill count.
module vote_history
  import cnn_vote_pkg::*;
#(
  parameter int VOTE_DEPTH = 5,
  parameter int FILL_W     = 3
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            clr,
  input  logic                            push,
  input  logic [CLS_W-1:0]                din,
  output logic [VOTE_DEPTH-1:0][CLS_W-1:0] entries,
  output logic                            fills_on_push
);

  logic [CLS_W-1:0]  entry_reg [VOTE_DEPTH];
  logic [FILL_W-1:0] fill_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < VOTE_DEPTH; i++) entry_reg[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < VOTE_DEPTH; i++) entry_reg[i] <= '0;
    end else if (push) begin
      entry_reg[0] <= din;
      for (int i = 1; i < VOTE_DEPTH; i++) entry_reg[i] <= entry_reg[i-1];
    end
  end

  // Fill saturates at the window depth; once full every accept triggers a vote.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fill_reg <= '0;
    end else if (clr) begin
      fill_reg <= '0;
    end else if (push && (fill_reg != FILL_W'(VOTE_DEPTH))) begin
      fill_reg <= fill_reg + 1'b1;
    end
  end

  assign fills_on_push = (fill_reg >= FILL_W'(VOTE_DEPTH - 1));

  genvar gi;
  generate
    for (gi = 0; gi < VOTE_DEPTH; gi++) begin : g_out
      assign entries[gi] = entry_reg[gi];
    end
  endgenerate

endmodule

// File: rtl/class_vote_tracker.sv
// Majority vote over recent CNN classifications with histogram, fault counting and alarm.
module class_vote_tracker
  import cnn_vote_pkg::*;
#(
  parameter int NUM_CLASSES   = CNN_NUM_CLASSES,
  parameter int HEALTHY_CLASS = CNN_HEALTHY_CLASS,
  parameter int VOTE_DEPTH    = 5,
  parameter int ALARM_THRESH  = 3,
  parameter int ADDR_LIMIT    = CNN_ADDR_LIMIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CLS_W-1:0]  cls_in,
  input  logic              cls_valid,
  input  logic [ADDR_W-1:0] address,
  input  logic              clr,
  input  logic [CLS_W-1:0]  rd_sel,
  output logic [HIST_W-1:0] rd_count,
  output logic [CLS_W-1:0]  vote_class,
  output logic              vote_valid,
  output logic              busy,
  output logic [ERR_W-1:0]  error_counter,
  output logic              fault_alarm,
  output logic              bad_class
);

  localparam int FILL_W   = clog2_min1(VOTE_DEPTH + 1);
  localparam int TALLY_W  = clog2_min1(VOTE_DEPTH + 1);
  localparam int TIDX_W   = clog2_min1(VOTE_DEPTH);
  localparam int CONSEC_W = clog2_min1(ALARM_THRESH + 1);

  localparam logic [ADDR_W-1:0] ADDR_LIM_V = ADDR_W'(ADDR_LIMIT);
  localparam logic [CLS_W-1:0]  HEALTHY_V  = CLS_W'(HEALTHY_CLASS);
  localparam logic [CLS_W:0]    NUM_CLS_V  = (CLS_W+1)'(NUM_CLASSES);

  logic [1:0]                       state_reg;
  logic [TIDX_W-1:0]                tidx_reg;
  cls_t                             decided_reg;
  logic                             pend_reg;
  logic [TALLY_W-1:0]               tally_reg [NUM_CLASSES];
  logic [HIST_W-1:0]                hist_reg [NUM_CLASSES];
  logic [CONSEC_W-1:0]              consec_reg;
  logic [VOTE_DEPTH-1:0][CLS_W-1:0] entries;
  logic                             fills_on_push;
  logic                             in_range;
  logic                             accept;
  logic                             start_vote;
  logic                             in_window;
  logic                             rd_hit;
  cls_t                             cur_entry;
  cls_t                             best_cls;
  logic [TALLY_W-1:0]               best_cnt;
  logic [NUM_CLASSES-1:0]           tally_hit;
  logic [NUM_CLASSES-1:0]           vote_hit;

  assign busy       = (state_reg != ST_IDLE);
  assign in_range   = ({1'b0, cls_in} < NUM_CLS_V);
  assign accept     = cls_valid && !busy && in_range;
  assign start_vote = accept && fills_on_push;
  assign in_window  = (address <= ADDR_LIM_V);
  assign rd_hit     = ({1'b0, rd_sel} < NUM_CLS_V);
  assign cur_entry  = entries[tidx_reg];

  vote_history #(
    .VOTE_DEPTH (VOTE_DEPTH),
    .FILL_W     (FILL_W)
  ) u_history (
    .clk           (clk),
    .reset         (reset),
    .clr           (clr),
    .push          (accept),
    .din           (cls_in),
    .entries       (entries),
    .fills_on_push (fills_on_push)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CLASSES; gi++) begin : g_hit
      assign tally_hit[gi] = (cur_entry == CLS_W'(gi));
      assign vote_hit[gi]  = (decided_reg == CLS_W'(gi));
    end
  endgenerate

  // Strict greater-than keeps the lowest class index on ties.
  always_comb begin
    best_cls = '0;
    best_cnt = tally_reg[0];
    for (int i = 1; i < NUM_CLASSES; i++) begin
      if (tally_reg[i] > best_cnt) begin
        best_cnt = tally_reg[i];
        best_cls = CLS_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= ST_IDLE;
      tidx_reg    <= '0;
      decided_reg <= '0;
      pend_reg    <= 1'b0;
    end else if (clr) begin
      state_reg   <= ST_IDLE;
      tidx_reg    <= '0;
      decided_reg <= '0;
      pend_reg    <= 1'b0;
    end else begin
      pend_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start_vote) begin
            state_reg <= ST_TALLY;
            tidx_reg  <= '0;
          end
        end
        ST_TALLY: begin
          if (tidx_reg == TIDX_W'(VOTE_DEPTH - 1)) begin
            state_reg <= ST_DECIDE;
          end else begin
            tidx_reg <= tidx_reg + 1'b1;
          end
        end
        ST_DECIDE: begin
          decided_reg <= best_cls;
          pend_reg    <= 1'b1;
          state_reg   <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CLASSES; i++) tally_reg[i] <= '0;
    end else if (clr || start_vote) begin
      for (int i = 0; i < NUM_CLASSES; i++) tally_reg[i] <= '0;
    end else if (state_reg == ST_TALLY) begin
      for (int i = 0; i < NUM_CLASSES; i++) begin
        if (tally_hit[i]) tally_reg[i] <= tally_reg[i] + 1'b1;
      end
    end
  end

  // vote_class doubles as the previous vote for the change-detection rule.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vote_class    <= '0;
      vote_valid    <= 1'b0;
      error_counter <= '0;
      consec_reg    <= '0;
      fault_alarm   <= 1'b0;
    end else if (clr) begin
      vote_class    <= '0;
      vote_valid    <= 1'b0;
      error_counter <= '0;
      consec_reg    <= '0;
      fault_alarm   <= 1'b0;
    end else begin
      vote_valid <= pend_reg;
      if (pend_reg) begin
        vote_class <= decided_reg;
        if (decided_reg != HEALTHY_V) begin
          if ((decided_reg != vote_class) && in_window && (error_counter != '1)) begin
            error_counter <= error_counter + 1'b1;
          end
          if (consec_reg != CONSEC_W'(ALARM_THRESH)) consec_reg <= consec_reg + 1'b1;
          if (consec_reg >= CONSEC_W'(ALARM_THRESH - 1)) fault_alarm <= 1'b1;
        end else begin
          consec_reg  <= '0;
          fault_alarm <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CLASSES; i++) hist_reg[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < NUM_CLASSES; i++) hist_reg[i] <= '0;
    end else if (pend_reg) begin
      for (int i = 0; i < NUM_CLASSES; i++) begin
        if (vote_hit[i] && (hist_reg[i] != '1)) hist_reg[i] <= hist_reg[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_count <= '0;
    end else if (clr) begin
      rd_count <= '0;
    end else begin
      rd_count <= rd_hit ? hist_reg[rd_sel] : '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bad_class <= 1'b0;
    end else if (clr) begin
      bad_class <= 1'b0;
    end else if (cls_valid && !busy && !in_range) begin
      bad_class <= 1'b1;
    end
  end

endmodule

// File: tb/tb_class_vote_tracker.sv
// Bench for class_vote_tracker: directed scenarios plus random traffic against a queue-based model.
module tb_class_vote_tracker;

  localparam int NC = 10;
  localparam int HC = 7;
  localparam int VD = 5;
  localparam int AT = 3;
  localparam int AL = 512000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  cls_in = '0;
  logic        cls_valid = 1'b0;
  logic [18:0] address = '0;
  logic        clr = 1'b0;
  logic [3:0]  rd_sel = '0;
  logic [15:0] rd_count;
  logic [3:0]  vote_class;
  logic        vote_valid;
  logic        busy;
  logic [3:0]  error_counter;
  logic        fault_alarm;
  logic        bad_class;

  class_vote_tracker #(
    .NUM_CLASSES   (NC),
    .HEALTHY_CLASS (HC),
    .VOTE_DEPTH    (VD),
    .ALARM_THRESH  (AT),
    .ADDR_LIMIT    (AL)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .cls_in        (cls_in),
    .cls_valid     (cls_valid),
    .address       (address),
    .clr           (clr),
    .rd_sel        (rd_sel),
    .rd_count      (rd_count),
    .vote_class    (vote_class),
    .vote_valid    (vote_valid),
    .busy          (busy),
    .error_counter (error_counter),
    .fault_alarm   (fault_alarm),
    .bad_class     (bad_class)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int vote_seen = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: newest-first queue of accepted classes and cycle-stamped vote schedule.
  int hq[$];
  int cyc = 0;
  int busy_end = 0;
  int vote_due = -1;
  int pend_cls = 0;
  int m_vclass = 0, m_vvalid = 0, m_err = 0, m_consec = 0;
  int m_alarm = 0, m_bad = 0, m_rd = 0, m_busy = 0, rd_next = 0;
  int m_hist[16];

  function automatic int majority();
    int cnt[16];
    int best;
    for (int i = 0; i < 16; i++) cnt[i] = 0;
    foreach (hq[i]) cnt[hq[i]]++;
    best = 0;
    for (int c = 1; c < NC; c++) if (cnt[c] > cnt[best]) best = c;
    return best;
  endfunction

  function automatic void model_clear();
    hq.delete();
    busy_end = 0;
    vote_due = -1;
    m_vclass = 0;
    m_err = 0;
    m_consec = 0;
    m_alarm = 0;
    m_bad = 0;
    for (int i = 0; i < 16; i++) m_hist[i] = 0;
  endfunction

  initial model_clear();

  always @(posedge clk) begin
    cyc++;
    m_vvalid = 0;
    if (!reset) begin
      model_clear();
      m_rd = 0;
    end else begin
      rd_next = (rd_sel < NC) ? m_hist[rd_sel] : 0;
      if (clr) begin
        model_clear();
        rd_next = 0;
      end else begin
        if (vote_due == cyc) begin
          m_vvalid = 1;
          if (pend_cls != HC) begin
            if (pend_cls != m_vclass && address <= AL && m_err < 15) m_err++;
            m_consec++;
            if (m_consec >= AT) m_alarm = 1;
          end else begin
            m_consec = 0;
            m_alarm = 0;
          end
          if (m_hist[pend_cls] < 65535) m_hist[pend_cls]++;
          m_vclass = pend_cls;
          vote_due = -1;
        end
        if (cls_valid && m_busy == 0) begin
          if (cls_in < NC) begin
            hq.push_front(int'(cls_in));
            if (hq.size() > VD) void'(hq.pop_back());
            if (hq.size() == VD) begin
              pend_cls = majority();
              vote_due = cyc + VD + 2;
              busy_end = cyc + VD + 1;
            end
          end else begin
            m_bad = 1;
          end
        end
      end
      m_rd = rd_next;
    end
    m_busy = (cyc < busy_end) ? 1 : 0;
  end

  always @(posedge clk) begin
    #2;
    chk("vote_valid", int'(vote_valid), m_vvalid);
    chk("vote_class", int'(vote_class), m_vclass);
    chk("busy", int'(busy), m_busy);
    chk("error_counter", int'(error_counter), m_err);
    chk("fault_alarm", int'(fault_alarm), m_alarm);
    chk("bad_class", int'(bad_class), m_bad);
    chk("rd_count", int'(rd_count), m_rd);
    if (vote_valid) vote_seen++;
  end

  // One accept; lat = cycles from the accepting edge to vote_valid, or -1 if none within 12.
  task automatic push(input int c, output int lat);
    @(negedge clk);
    cls_in = 4'(c);
    cls_valid = 1'b1;
    @(posedge clk);
    #1 cls_valid = 1'b0;
    lat = -1;
    for (int k = 1; k <= 12 && lat < 0; k++) begin
      @(posedge clk);
      #3;
      if (vote_valid) lat = k;
    end
  endtask

  task automatic push_quiet(input string name, input int c);
    int lat;
    push(c, lat);
    chk(name, lat, -1);
  endtask

  task automatic push_vote(input string name, input int c, input int exp_cls);
    int lat;
    push(c, lat);
    chk({name, "_lat"}, lat, VD + 2);
    chk({name, "_cls"}, int'(vote_class), exp_cls);
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  int lat;
  int vc0;

  initial begin
    address = 19'd1000;
    repeat (3) @(negedge clk);
    chk("rst_vote_class", int'(vote_class), 0);
    chk("rst_vote_valid", int'(vote_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(error_counter), 0);
    chk("rst_alarm", int'(fault_alarm), 0);
    chk("rst_bad", int'(bad_class), 0);
    chk("rst_rd", int'(rd_count), 0);
    reset = 1'b1;

    for (int i = 0; i < 4; i++) push_quiet("fill_no_vote", 3);
    push_vote("fill_vote", 3, 3);
    @(negedge clk);
    rd_sel = 4'd3;
    @(negedge clk);
    chk("rd_hist3", int'(rd_count), 1);

    do_clr();
    push_quiet("maj_fill", 7);
    push_quiet("maj_fill", 5);
    push_quiet("maj_fill", 5);
    push_quiet("maj_fill", 2);
    push_vote("tie_2_5", 2, 2);
    do_clr();
    push_quiet("maj_fill", 7);
    push_quiet("maj_fill", 7);
    push_quiet("maj_fill", 4);
    push_quiet("maj_fill", 4);
    push_vote("maj_4", 4, 4);

    do_clr();
    address = 19'd1000;
    for (int i = 0; i < 4; i++) push_quiet("alarm_fill", 1);
    push_vote("alarm_v1", 1, 1);
    push_vote("alarm_v2", 1, 1);
    chk("alarm_after2", int'(fault_alarm), 0);
    push_vote("alarm_v3", 1, 1);
    chk("alarm_set", int'(fault_alarm), 1);
    chk("alarm_err", int'(error_counter), 1);
    push_vote("alarm_v4", 7, 1);
    push_vote("alarm_v5", 7, 1);
    push_vote("alarm_v6", 7, 7);
    chk("alarm_cleared", int'(fault_alarm), 0);
    chk("alarm_err_keep", int'(error_counter), 1);

    // 600000 does not fit the 19-bit address; any address above the limit shows the gating.
    do_clr();
    address = 19'd520000;
    for (int i = 0; i < 5; i++) push(1, lat);
    for (int a = 1; a <= 6; a++)
      for (int j = 0; j < 3; j++) push((a % 2 == 1) ? 2 : 1, lat);
    chk("err_gated", int'(error_counter), 0);
    address = 19'd1000;
    for (int a = 1; a <= 20; a++)
      for (int j = 0; j < 3; j++) push((a % 2 == 1) ? 2 : 1, lat);
    chk("err_saturate", int'(error_counter), 15);

    do_clr();
    push_quiet("filt_fill", 2);
    push_quiet("filt_fill", 2);
    @(negedge clk);
    cls_in = 4'd12;
    cls_valid = 1'b1;
    @(negedge clk);
    cls_valid = 1'b0;
    chk("bad_class_set", int'(bad_class), 1);
    push_quiet("filt_fill_unchanged", 2);
    push_quiet("filt_fill_unchanged", 2);
    push_vote("filt_vote", 2, 2);
    @(negedge clk);
    cls_in = 4'd4;
    cls_valid = 1'b1;
    @(posedge clk);
    #1 cls_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    cls_in = 4'd9;
    cls_valid = 1'b1;
    @(negedge clk);
    cls_valid = 1'b0;
    vc0 = vote_seen;
    repeat (20) @(negedge clk);
    chk("busy_ignore_votes", vote_seen - vc0, 1);
    chk("busy_ignore_cls", int'(vote_class), 2);

    do_clr();
    for (int i = 0; i < 4; i++) push_quiet("clr_fill", 6);
    @(negedge clk);
    cls_in = 4'd6;
    cls_valid = 1'b1;
    @(posedge clk);
    #1 cls_valid = 1'b0;
    repeat (VD) @(posedge clk);
    #3;
    chk("decide_busy", int'(busy), 1);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    vc0 = vote_seen;
    rd_sel = 4'd6;
    repeat (12) @(negedge clk);
    chk("clr_no_vote", vote_seen - vc0, 0);
    chk("clr_err", int'(error_counter), 0);
    chk("clr_hist6", int'(rd_count), 0);
    chk("clr_idle", int'(busy), 0);
    for (int i = 0; i < 4; i++) push_quiet("rd_fill", 3);
    push_vote("rd_vote", 3, 3);
    @(negedge clk);
    rd_sel = 4'd3;
    @(negedge clk);
    chk("rd_sel3", int'(rd_count), 1);
    rd_sel = 4'd11;
    @(negedge clk);
    chk("rd_sel11", int'(rd_count), 0);

    do_clr();
    for (int i = 0; i < 4; i++) push_quiet("rst_fill", 5);
    @(negedge clk);
    cls_in = 4'd5;
    cls_valid = 1'b1;
    @(posedge clk);
    #1 cls_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    vc0 = vote_seen;
    repeat (12) @(negedge clk);
    chk("rst_mid_no_vote", vote_seen - vc0, 0);
    chk("rst_mid_busy", int'(busy), 0);

    repeat (3000) begin
      @(negedge clk);
      cls_valid = ($urandom_range(0, 99) < 45);
      case ($urandom_range(0, 9))
        0:       cls_in = 4'($urandom_range(10, 15));
        1, 2, 3: cls_in = 4'd7;
        4, 5:    cls_in = 4'd1;
        default: cls_in = 4'($urandom_range(0, 9));
      endcase
      address = ($urandom_range(0, 3) == 0) ? 19'($urandom_range(512001, 524287))
                                           : 19'($urandom_range(0, 512000));
      clr = ($urandom_range(0, 299) == 0);
      rd_sel = 4'($urandom_range(0, 15));
    end
    @(negedge clk);
    cls_valid = 1'b0;
    clr = 1'b0;
    repeat (12) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
